// File: rtl/sample_dumper.sv
// sample_dumper
//   Streams the circular sample memory to the UART transmitter after a capture.
//   The dump starts at the oldest sample, which is the trigger offset plus half
//   the buffer, and wraps naturally across the address space. Samples wider than
//   8 bits are sent as two bytes, MSB byte first and zero-extended.
//   Optional build macro: SAMPLE_DUMPER_CHECKSUM_EN. When it is defined, a trailing
//   two's-complement checksum byte is sent after the data bytes.
//
// Ports:
//   clk_50mhz  system clock
//   reset      asynchronous, active-high reset
//   activate   level input; a rising edge seen in IDLE starts a dump
//   done       high from dump completion until activate goes low
//   offset     trigger address from the sampler, sampled at dump start
//   mem_addr   registered RAM read address
//   mem_re     RAM read enable; read data is valid one clock later
//   mem_data   RAM read data
//   tx_active  UART busy flag
//   tx_start   one-cycle pulse that launches tx_data
//   tx_data    byte to transmit, held until the UART finishes

module sample_dumper #(
    parameter int SAMPLE_DEPTH = 8,
    parameter int WIDTH        = 8
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    activate,
    output logic                    done,
    input  logic [SAMPLE_DEPTH-1:0] offset,
    output logic [SAMPLE_DEPTH-1:0] mem_addr,
    output logic                    mem_re,
    input  logic [WIDTH-1:0]        mem_data,
    input  logic                    tx_active,
    output logic                    tx_start,
    output logic [7:0]              tx_data
);

    // Half the buffer lies before the trigger, so offset+HALF is the oldest sample.
    localparam logic [SAMPLE_DEPTH-1:0] HALF = SAMPLE_DEPTH'(1 << (SAMPLE_DEPTH - 1));
    localparam int BPS = (WIDTH <= 8) ? 1 : 2;

    typedef enum logic [3:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE,
        NEXT,
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
        CSUM,
`endif
        FINISH
    } state_t;

    state_t                  state;
    logic                    activate_q;
    logic [SAMPLE_DEPTH-1:0] sample_cnt;
    logic [WIDTH-1:0]        sample;
    logic                    byte_idx;
    logic [1:0]              tmo_cnt;
    logic [15:0]             sample_ext;
    logic [7:0]              sel_byte;
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
    logic [7:0]              csum;
    logic                    csum_phase;
`endif

    // Byte presented to the UART: the selected half of the sample, or the
    // negated running sum while the checksum byte is being sent.
    always_comb begin
        sample_ext = '0;
        sample_ext[WIDTH-1:0] = sample;
        sel_byte = byte_idx ? sample_ext[15:8] : sample_ext[7:0];
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
        if (csum_phase) begin
            sel_byte = ~csum + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            activate_q <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            sample_cnt <= '0;
            sample     <= '0;
            byte_idx   <= 1'b0;
            tmo_cnt    <= '0;
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
        end else begin
            activate_q <= activate;
            tx_start   <= 1'b0;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (activate && !activate_q) begin
                        mem_addr   <= offset + HALF;
                        sample_cnt <= '0;
                        mem_re     <= 1'b1;
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
                        csum       <= '0;
                        csum_phase <= 1'b0;
`endif
                        state      <= READ;
                    end
                end
                READ: begin
                    // mem_re was raised on entry, so it is high for exactly this cycle.
                    mem_re <= 1'b0;
                    state  <= LATCH;
                end
                LATCH: begin
                    sample   <= mem_data;
                    mem_re   <= 1'b0;
                    byte_idx <= 1'(BPS - 1);
                    state    <= SEND;
                end
                SEND: begin
                    tx_data <= sel_byte;
                    if (!tx_active) begin
                        tx_start <= 1'b1;
                        tmo_cnt  <= '0;
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
                        if (!csum_phase) begin
                            csum <= csum + sel_byte;
                        end
`endif
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // A UART that never raises busy is treated as done after 4 cycles.
                    if (tx_active || tmo_cnt == 2'd3) begin
                        state <= WAIT_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 2'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (!tx_active) begin
                        if (byte_idx) begin
                            byte_idx <= byte_idx - 1'b1;
                            state    <= SEND;
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
                        end else if (csum_phase) begin
                            done  <= 1'b1;
                            state <= FINISH;
`endif
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (sample_cnt == '1) begin
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
                        state <= CSUM;
`else
                        done  <= 1'b1;
                        state <= FINISH;
`endif
                    end else begin
                        mem_addr   <= mem_addr + 1'b1;
                        sample_cnt <= sample_cnt + 1'b1;
                        mem_re     <= 1'b1;
                        state      <= READ;
                    end
                end
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
                CSUM: begin
                    csum_phase <= 1'b1;
                    byte_idx   <= 1'b0;
                    state      <= SEND;
                end
`endif
                FINISH: begin
                    done <= 1'b1;
                    if (!activate) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sample_dumper.md
Name: sample_dumper

Overview:
- Read-out counterpart of the acquisition sampler.
- After a capture completes, it reads the circular sample memory in chronological order and streams every sample byte to the UART transmitter. It starts at the oldest sample and wraps around the buffer using the captured trigger offset.
- Sits between the sample RAM read port and uart_tx. It is driven by the top-level command FSM through an activate/done handshake.

Parameters:
SAMPLE_DEPTH, 8, address width; buffer holds 2^SAMPLE_DEPTH samples
WIDTH, 8, sample width in bits; legal range 1..16
HALF, 2^(SAMPLE_DEPTH-1), pre-trigger span; derived, not overridable

Ports:
clk_50mhz  input  1  system clock
reset  input  1  asynchronous, active-high reset
activate  input  1  level; a rising edge seen in IDLE starts a dump
done  output  1  high from dump completion until activate goes low
offset  input  SAMPLE_DEPTH  trigger address from the sampler; sampled at start
mem_addr  output  SAMPLE_DEPTH  registered RAM read address
mem_re  output  1  read enable, high while a read is outstanding
mem_data  input  WIDTH  RAM read data; valid one clk after mem_addr/mem_re
tx_active  input  1  UART busy flag
tx_start  output  1  one-cycle pulse to start transmission of tx_data
tx_data  output  8  byte to transmit; held stable from tx_start until tx_active falls

Behaviour:
- Reset values: done=0, mem_addr=0, mem_re=0, tx_start=0, tx_data=0, state=IDLE, counters=0. Reset is asynchronous and aborts a dump in any state; no partial byte is sent after reset.
- Byte count: BPS = 1 if WIDTH<=8, else 2. Multi-byte samples are sent MSB byte first. The MSB byte is zero-extended to 8 bits.
- Start address: start = (offset + HALF) mod 2^SAMPLE_DEPTH, which is the oldest sample. Address wraps naturally at 2^SAMPLE_DEPTH.
- States:
  - IDLE: done=0. When activate=1 and the previous activate was 0, latch start into mem_addr, clear sample_cnt, go to READ.
  - READ: mem_re=1 for one cycle, go to LATCH.
  - LATCH: capture mem_data into the sample register, mem_re=0, set byte_idx=BPS-1, go to SEND.
  - SEND: load tx_data from the selected byte. When tx_active=0, pulse tx_start for 1 cycle and go to WAIT_BUSY. While tx_active=1, stay with tx_start=0.
  - WAIT_BUSY: wait for tx_active=1, then go to WAIT_IDLE. Timeout: if tx_active stays 0 for 4 cycles, treat the byte as sent and go to WAIT_IDLE.
  - WAIT_IDLE: wait for tx_active=0. Then if byte_idx>0, decrement it and go to SEND. Otherwise go to NEXT.
  - NEXT: if sample_cnt == 2^SAMPLE_DEPTH-1, go to FINISH (or CSUM, see Optional Feature). Else increment mem_addr (wrapping) and sample_cnt, go to READ.
  - FINISH: done=1. When activate=0, go to IDLE (done drops on the next cycle).
- Exactly 2^SAMPLE_DEPTH*BPS data bytes are sent per dump. Each address is read exactly once.
- Latency: activate rise to first tx_start is 4 cycles when tx_active=0.
- activate falling mid-dump does not abort; the dump completes and done then pulses for 1 cycle.
- activate still high in FINISH holds done=1 indefinitely, and no new dump starts until activate returns to 0.
- offset changes during a dump are ignored.

Optional Feature:
- Macro: SAMPLE_DUMPER_CHECKSUM_EN.
- Defined:
  - Maintain an 8-bit sum mod 256 of every data byte sent, cleared at dump start.
  - After the last data byte, the CSUM state transmits the two's complement of that sum, using the same SEND/WAIT handshake, then goes to FINISH.
  - The sum of all bytes including the checksum is 0 mod 256.
- Not defined: no CSUM state; NEXT goes directly to FINISH and the byte count is exactly 2^SAMPLE_DEPTH*BPS.

Test Plan:
- SAMPLE_DEPTH=8, WIDTH=8, RAM[a]=a, offset=0x10, activate 0->1, tx model busy 10 cycles per byte -> 256 bytes 0x90,0x91..0xFF,0x00..0x8F, then done=1.
- offset=0x7F -> first byte 0xFF, second 0x00, last 0xFE (wrap). offset=0x80 -> first byte 0x00, last 0xFF.
- WIDTH=12, SAMPLE_DEPTH=2, RAM={0xABC,0x123,0x456,0x789}, offset=0 -> bytes 0x04,0x56,0x07,0x89,0x0A,0xBC,0x01,0x23.
- tx_active held 1 for 50 cycles at activate -> no tx_start until it drops; tx_data stable while tx_start=1. tx_active never rises -> 4-cycle timeout per byte, dump still completes.
- Assert reset on the 100th byte -> all outputs at reset values immediately, no further tx_start. A following activate restarts from the first byte.
- With SAMPLE_DUMPER_CHECKSUM_EN, SAMPLE_DEPTH=2, RAM={1,2,3,4}, offset=0 -> bytes 0x03,0x04,0x01,0x02,0xF6.
